spi_mem_slave: RTL

Synthesizable SPI/QPI slave that answers the memory-load command stream a host (tester, boot flash programmer or bench master) issues during bring-up. It decodes 8-bit commands, a 32-bit address and streamed 32-bit words, and turns them into single-beat requests on a simple memory port in front of the L2/AXI bridge. It also holds the QPI-enable configuration register. The SPI pins are oversampled in the system clock domain, so the block has one clock.

---
 rtl/spi_mem_slave.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_mem_slave.sv
// spi_mem_slave: SPI/QPI slave bridging the host memory-load command stream to a single-beat memory port.
// Ports: clk/rst_n; SPI pins spi_clk_i, spi_cs_i, spi_sdi[0-3]_i, spi_sdo[0-3]_o, spi_mode_o; memory port mem_*; sticky err_o.
module spi_mem_slave #(
   parameter int unsigned DUMMY_CYCLES = 32,
   parameter int unsigned ADDR_INC     = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        spi_clk_i,
   input  logic        spi_cs_i,
   input  logic        spi_sdi0_i,
   input  logic        spi_sdi1_i,
   input  logic        spi_sdi2_i,
   input  logic        spi_sdi3_i,
   output logic        spi_sdo0_o,
   output logic        spi_sdo1_o,
   output logic        spi_sdo2_o,
   output logic        spi_sdo3_o,
   output logic [1:0]  spi_mode_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        err_o
);

   typedef enum logic [3:0] {
      IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, CFG_WR, CFG_RD, IGNORE
   } state_t;

   localparam logic [7:0]  CMD_CFG_WR = 8'h01;
   localparam logic [7:0]  CMD_CFG_RD = 8'h05;
   localparam logic [7:0]  CMD_WR     = 8'h02;
   localparam logic [7:0]  CMD_RD     = 8'h0B;
   localparam logic [31:0] INC        = 32'(ADDR_INC);
   localparam logic [5:0]  DUMMY_LAST = 6'(DUMMY_CYCLES - 1);

   state_t      state, state_n;
   logic [1:0]  sck_sync, cs_sync;
   logic [3:0]  sdi_m, sdi_s;
   logic        sck_d, cs_d;
   logic        rise, fall, cs_fall, cs_rise;
   logic        qpi_en, cfg_pend, cfg_upd;
   logic [5:0]  cnt, cnt_n, ocnt, ocnt_n, step;
   logic [31:0] sr, sr_n, tx, addr, rbuf, load_word;
   logic [7:0]  cmd;
   logic        bits_done, dummy_done, driving;
   logic        want_rd, rd_wait, req_stale, rbuf_v;
   logic        busy, rd_gnt, rv_take, rv_drop, drop_inc;
   logic [1:0]  drop;

   // Two-flop synchronizers plus one edge-history flop per strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_sync <= 2'b00;
         cs_sync  <= 2'b11;
         sdi_m    <= 4'h0;
         sdi_s    <= 4'h0;
         sck_d    <= 1'b0;
         cs_d     <= 1'b1;
      end else begin
         sck_sync <= {sck_sync[0], spi_clk_i};
         cs_sync  <= {cs_sync[0], spi_cs_i};
         sdi_m    <= {spi_sdi3_i, spi_sdi2_i, spi_sdi1_i, spi_sdi0_i};
         sdi_s    <= sdi_m;
         sck_d    <= sck_sync[1];
         cs_d     <= cs_sync[1];
      end
   end

   always_comb begin
      rise       = sck_sync[1] & ~sck_d;
      fall       = ~sck_sync[1] & sck_d;
      cs_fall    = ~cs_sync[1] & cs_d;
      cs_rise    = cs_sync[1] & ~cs_d;
      step       = qpi_en ? 6'd4 : 6'd1;
      cnt_n      = cnt + step;
      ocnt_n     = ocnt + step;
      sr_n       = qpi_en ? {sr[27:0], sdi_s} : {sr[30:0], sdi_s[0]};
      bits_done  = (state == CMD || state == CFG_WR) ? (cnt_n == 6'd8)
                                                     : (cnt_n == 6'd32);
      dummy_done = rise && (cnt == DUMMY_LAST);
      driving    = (state == RDATA) || (state == CFG_RD);
      busy       = mem_req_o && !mem_gnt_i;
      rd_gnt     = mem_req_o && mem_gnt_i && !mem_we_o;
      // Responses for reads orphaned by CS deassert are counted and discarded.
      rv_drop    = mem_rvalid_i && (drop != 2'd0);
      rv_take    = mem_rvalid_i && (drop == 2'd0) && rd_wait;
      drop_inc   = (rd_gnt && (req_stale || cs_rise))
                 || (cs_rise && rd_wait && !rv_take);
      load_word  = (state == CFG_RD) ? {7'b0, qpi_en, 24'b0}
                                     : (rbuf_v ? rbuf : 32'h0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (cs_rise) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE:   if (cs_fall) state_n = CMD;
            CMD:
               if (rise && bits_done) begin
                  case (sr_n[7:0])
                     CMD_CFG_WR:     state_n = CFG_WR;
                     CMD_CFG_RD:     state_n = CFG_RD;
                     CMD_WR, CMD_RD: state_n = ADDR;
                     default:        state_n = IGNORE;
                  endcase
               end
            ADDR:
               if (rise && bits_done)
                  state_n = (cmd == CMD_WR) ? WDATA : DUMMY;
            DUMMY:  if (dummy_done) state_n = RDATA;
            CFG_WR: if (rise && bits_done) state_n = IGNORE;
            default: state_n = state;
         endcase
      end
   end

   always_comb begin
      spi_mode_o = 2'b00;
      if (qpi_en) spi_mode_o = driving ? 2'b01 : 2'b10;
      {spi_sdo3_o, spi_sdo2_o, spi_sdo1_o, spi_sdo0_o} = 4'h0;
      if (driving) begin
         if (qpi_en)
            {spi_sdo3_o, spi_sdo2_o, spi_sdo1_o, spi_sdo0_o} = tx[31:28];
         else
            spi_sdo0_o = tx[31];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qpi_en      <= 1'b0;
         cfg_pend    <= 1'b0;
         cfg_upd     <= 1'b0;
         cnt         <= 6'd0;
         ocnt        <= 6'd0;
         sr          <= 32'h0;
         tx          <= 32'h0;
         cmd         <= 8'h0;
         addr        <= 32'h0;
         rbuf        <= 32'h0;
         rbuf_v      <= 1'b0;
         want_rd     <= 1'b0;
         rd_wait     <= 1'b0;
         req_stale   <= 1'b0;
         drop        <= 2'd0;
         err_o       <= 1'b0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= 32'h0;
         mem_wdata_o <= 32'h0;
      end else begin
         if (mem_req_o && mem_gnt_i) begin
            mem_req_o <= 1'b0;
            req_stale <= 1'b0;
         end
         if (rd_gnt && !(req_stale || cs_rise)) rd_wait <= 1'b1;
         drop <= drop + {1'b0, drop_inc} - {1'b0, rv_drop};
         if (rv_take) begin
            rbuf    <= mem_rdata_i;
            rbuf_v  <= 1'b1;
            rd_wait <= 1'b0;
         end

         if (want_rd && !busy && !rd_wait && !cs_rise) begin
            mem_req_o  <= 1'b1;
            mem_we_o   <= 1'b0;
            mem_addr_o <= addr;
            addr       <= addr + INC;
            want_rd    <= 1'b0;
         end

         case (state)
            CMD, ADDR, WDATA, CFG_WR:
               if (rise) begin
                  sr  <= sr_n;
                  cnt <= bits_done ? 6'd0 : cnt_n;
                  if (bits_done) begin
                     case (state)
                        CMD:  cmd <= sr_n[7:0];
                        ADDR: begin
                           addr <= sr_n;
                           if (cmd == CMD_RD) want_rd <= 1'b1;
                        end
                        WDATA:
                           // A word landing on a still-pending request is lost.
                           if (busy) begin
                              err_o <= 1'b1;
                           end else begin
                              mem_req_o   <= 1'b1;
                              mem_we_o    <= 1'b1;
                              mem_addr_o  <= addr;
                              mem_wdata_o <= sr_n;
                              addr        <= addr + INC;
                           end
                        default: begin
                           cfg_pend <= sr_n[0];
                           cfg_upd  <= 1'b1;
                        end
                     endcase
                  end
               end
            DUMMY:
               if (rise) cnt <= dummy_done ? 6'd0 : cnt + 6'd1;
            RDATA, CFG_RD:
               if (fall) begin
                  if (ocnt == 6'd0) begin
                     tx   <= load_word;
                     ocnt <= step;
                     if (state == RDATA) begin
                        if (rbuf_v) begin
                           rbuf_v  <= 1'b0;
                           want_rd <= 1'b1;
                        end else begin
                           err_o <= 1'b1;
                           if (!rd_wait && !(mem_req_o && !mem_we_o))
                              want_rd <= 1'b1;
                        end
                     end
                  end else begin
                     tx   <= qpi_en ? {tx[27:0], 4'h0} : {tx[30:0], 1'b0};
                     ocnt <= (ocnt_n == 6'd32) ? 6'd0 : ocnt_n;
                  end
               end
            default: ;
         endcase

         if (cs_rise) begin
            want_rd <= 1'b0;
            rd_wait <= 1'b0;
            cfg_upd <= 1'b0;
            if (busy)    req_stale <= 1'b1;
            if (cfg_upd) qpi_en    <= cfg_pend;
         end
         if (cs_fall) begin
            cnt    <= 6'd0;
            ocnt   <= 6'd0;
            tx     <= 32'h0;
            err_o  <= 1'b0;
            rbuf_v <= 1'b0;
         end
      end
   end

endmodule
